// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus: PCAdder loop, instruction-memory handshake and decode-facing outputs.
// The master modport belongs to pc_fetch_unit; the slave modport to its environment.
interface pc_fetch_unit_if;
  logic [31:0] PC;
  logic [31:0] pcPlus4;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        stall;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] instrPC;

  modport master (
    output PC, imemReq, imemAddr, instrValid, instr, instrPC,
    input  pcPlus4, branchTaken, branchTarget, stall, imemReady, imemData
  );

  modport slave (
    input  PC, imemReq, imemAddr, instrValid, instr, instrPC,
    output pcPlus4, branchTaken, branchTarget, stall, imemReady, imemData
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch controller: requests from imem at PC, captures the word,
// presents it to decode until consumed, and redirects on branches.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clock,
  input logic                reset,
  pc_fetch_unit_if.master    bus
);

  typedef enum logic [1:0] {
    StBoot  = 2'b00,
    StFetch = 2'b01,
    StIssue = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] target_aligned;

  assign target_aligned = {bus.branchTarget[31:2], 2'b00};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StBoot;
      pc_q       <= {RESET_PC[31:2], 2'b00};
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        // A redirect outranks a same-cycle memory response; that data is dropped.
        if (bus.branchTaken) begin
          pc_d = target_aligned;
        end else if (bus.imemReady) begin
          instr_d    = bus.imemData;
          instr_pc_d = pc_q;
          pc_d       = {bus.pcPlus4[31:2], 2'b00};
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (bus.branchTaken) begin
          pc_d    = target_aligned;
          state_d = StFetch;
        end else if (!bus.stall) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // Handshake outputs decode from state alone, so no input reaches them combinationally.
  assign bus.imemReq    = (state_q == StFetch);
  assign bus.instrValid = (state_q == StIssue);
  assign bus.PC         = pc_q;
  assign bus.imemAddr   = pc_q;
  assign bus.instr      = instr_q;
  assign bus.instrPC    = instr_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: free-run, wait states, stall, branches, wrap, async reset.
module tb_pc_fetch_unit;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic        data_ovr_en;
  logic [31:0] data_ovr;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // PCAdder and instruction memory models.
  always_comb begin
    bus.pcPlus4  = bus.PC + 32'd4;
    bus.imemData = data_ovr_en ? data_ovr : (bus.imemAddr ^ 32'hA5A5_0000);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " PC"}, bus.PC, 32'h0);
    check({tag, " instr"}, bus.instr, 32'h0);
    check({tag, " instrPC"}, bus.instrPC, 32'h0);
    check({tag, " valid"}, {31'h0, bus.instrValid}, 32'h0);
    check({tag, " req"}, {31'h0, bus.imemReq}, 32'h0);
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    data_ovr_en       = 1'b0;
    data_ovr          = 32'h0;
    reset             = 1'b0;
    bus.branchTaken   = 1'b0;
    bus.branchTarget  = 32'h0;
    bus.stall         = 1'b0;
    bus.imemReady     = 1'b0;

    #3 check_reset_vals("por");

    // Free-run from reset.
    @(negedge clock);
    reset         = 1'b1;
    bus.imemReady = 1'b1;
    @(negedge clock);
    check("boot req", {31'h0, bus.imemReq}, 32'h1);
    check("boot valid", {31'h0, bus.instrValid}, 32'h0);
    check("boot addr", bus.imemAddr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("run valid", {31'h0, bus.instrValid}, 32'h1);
      check("run req", {31'h0, bus.imemReq}, 32'h0);
      check("run instrPC", bus.instrPC, 32'(4 * k));
      check("run instr", bus.instr, 32'(4 * k) ^ 32'hA5A5_0000);
      check("run PC", bus.PC, 32'(4 * k + 4));
      @(negedge clock);
      check("run gap valid", {31'h0, bus.instrValid}, 32'h0);
      check("run gap req", {31'h0, bus.imemReq}, 32'h1);
    end

    // Three wait-state cycles at 0x10, capture on the fourth.
    bus.imemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("wait req", {31'h0, bus.imemReq}, 32'h1);
      check("wait addr", bus.imemAddr, 32'h10);
      check("wait valid", {31'h0, bus.instrValid}, 32'h0);
    end
    bus.imemReady = 1'b1;
    data_ovr_en   = 1'b1;
    data_ovr      = 32'h0050_0093;
    @(negedge clock);
    check("wait cap valid", {31'h0, bus.instrValid}, 32'h1);
    check("wait cap instrPC", bus.instrPC, 32'h10);
    check("wait cap PC", bus.PC, 32'h14);

    // Decode stall holds the presented instruction.
    data_ovr_en = 1'b0;
    bus.stall   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall valid", {31'h0, bus.instrValid}, 32'h1);
      check("stall instr", bus.instr, 32'h0050_0093);
      check("stall instrPC", bus.instrPC, 32'h10);
      check("stall PC", bus.PC, 32'h14);
      check("stall req", {31'h0, bus.imemReq}, 32'h0);
    end
    bus.stall = 1'b0;
    @(negedge clock);
    check("unstall valid", {31'h0, bus.instrValid}, 32'h0);
    check("unstall req", {31'h0, bus.imemReq}, 32'h1);
    @(negedge clock);
    check("refetch instrPC", bus.instrPC, 32'h14);
    check("refetch valid", {31'h0, bus.instrValid}, 32'h1);

    // Branch in ISSUE, with stall also high: branch wins.
    bus.branchTaken  = 1'b1;
    bus.stall        = 1'b1;
    bus.branchTarget = 32'h203;
    @(negedge clock);
    bus.stall = 1'b0;
    check("br issue valid", {31'h0, bus.instrValid}, 32'h0);
    check("br issue PC", bus.PC, 32'h200);
    check("br issue req", {31'h0, bus.imemReq}, 32'h1);

    // Branch coincident with imemReady in FETCH: data dropped.
    bus.branchTarget = 32'h303;
    @(negedge clock);
    check("br fetch valid", {31'h0, bus.instrValid}, 32'h0);
    check("br fetch PC", bus.PC, 32'h300);
    check("br fetch instrPC", bus.instrPC, 32'h14);
    bus.branchTaken = 1'b0;
    @(negedge clock);
    check("post br instrPC", bus.instrPC, 32'h300);
    check("post br instr", bus.instr, 32'hA5A5_0300);
    check("post br PC", bus.PC, 32'h304);

    // Wrap-around via pcPlus4.
    bus.branchTaken  = 1'b1;
    bus.branchTarget = 32'hFFFF_FFFF;
    @(negedge clock);
    check("wrap setup PC", bus.PC, 32'hFFFF_FFFC);
    bus.branchTaken = 1'b0;
    @(negedge clock);
    check("wrap instrPC", bus.instrPC, 32'hFFFF_FFFC);
    check("wrap instr", bus.instr, 32'h5A5A_FFFC);
    check("wrap PC", bus.PC, 32'h0);
    @(negedge clock);
    check("pre rst req", {31'h0, bus.imemReq}, 32'h1);

    // Asynchronous reset between edges while a fetch is outstanding.
    bus.imemReady = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_vals("async");
    @(negedge clock);
    check_reset_vals("async held");
    reset         = 1'b1;
    bus.imemReady = 1'b1;
    @(negedge clock);
    check("restart req", {31'h0, bus.imemReq}, 32'h1);
    check("restart valid", {31'h0, bus.instrValid}, 32'h0);
    @(negedge clock);
    check("restart cap valid", {31'h0, bus.instrValid}, 32'h1);
    check("restart cap instrPC", bus.instrPC, 32'h0);
    check("restart cap PC", bus.PC, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
